// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline sequencing controller.
//   ctrl_state_t : controller FSM states
//   pipe_ctrl_t  : bundle of PC enable, pipeline-register enables and flushes
package pipe_hazard_ctrl_pkg;

  // Register-file address width (rs1/rs2/rd).
  localparam int unsigned RegAddrW = 5;

  typedef enum logic [1:0] {
    StRun,
    StMemWait,
    StDrain,
    StHalted
  } ctrl_state_t;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_en;
    logic id_ex_flush;
    logic ex_mem_en;
    logic mem_wb_en;
  } pipe_ctrl_t;

  // Everything advances, nothing is squashed.
  localparam pipe_ctrl_t CtrlNormal = '{
    pc_en:       1'b1,
    if_id_en:    1'b1,
    if_id_flush: 1'b0,
    id_ex_en:    1'b1,
    id_ex_flush: 1'b0,
    ex_mem_en:   1'b1,
    mem_wb_en:   1'b1
  };

  // Whole pipeline holds its contents.
  localparam pipe_ctrl_t CtrlFreeze = '{
    pc_en:       1'b0,
    if_id_en:    1'b0,
    if_id_flush: 1'b0,
    id_ex_en:    1'b0,
    id_ex_flush: 1'b0,
    ex_mem_en:   1'b0,
    mem_wb_en:   1'b0
  };

  // Front end is held empty while EX, MEM and WB retire their instructions.
  localparam pipe_ctrl_t CtrlDrain = '{
    pc_en:       1'b0,
    if_id_en:    1'b1,
    if_id_flush: 1'b1,
    id_ex_en:    1'b1,
    id_ex_flush: 1'b1,
    ex_mem_en:   1'b1,
    mem_wb_en:   1'b1
  };

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector.
//   id_rs1, id_rs2 : source registers of the instruction in ID
//   ex_mem_read    : the instruction in ID/EX is a load
//   ex_rd          : destination register of the instruction in ID/EX
//   lu_hazard      : ID needs the load result before it can be forwarded
module load_use_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [RegAddrW-1:0] id_rs1,
  input  logic [RegAddrW-1:0] id_rs2,
  input  logic                ex_mem_read,
  input  logic [RegAddrW-1:0] ex_rd,
  output logic                lu_hazard
);

  // x0 is hard-wired to zero, so a load targeting it never creates a dependency.
  assign lu_hazard = ex_mem_read && (ex_rd != '0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central sequencing controller for the 5-stage pipeline.
// Inputs : clk, rst_n (async active-low), ID operands/halt, ID/EX load info,
//          EX redirect, EX/MEM memory request and data-memory ready.
// Outputs: PC/IF-ID/ID-EX/EX-MEM/MEM-WB enables and IF-ID/ID-EX flushes (combinational),
//          halted and mem_err (registered), saturating stall_cnt and flush_cnt.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned MEM_TIMEOUT  = 255,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [RegAddrW-1:0] id_rs1,
  input  logic [RegAddrW-1:0] id_rs2,
  input  logic                id_halt,
  input  logic                ex_mem_read,
  input  logic [RegAddrW-1:0] ex_rd,
  input  logic                ex_redirect,
  input  logic                mem_req,
  input  logic                mem_ready,
  output logic                pc_en,
  output logic                if_id_en,
  output logic                if_id_flush,
  output logic                id_ex_en,
  output logic                id_ex_flush,
  output logic                ex_mem_en,
  output logic                mem_wb_en,
  output logic                halted,
  output logic                mem_err,
  output logic [CNT_W-1:0]    stall_cnt,
  output logic [CNT_W-1:0]    flush_cnt
);

  localparam int unsigned WaitW  = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam int unsigned DrainW = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
  localparam logic [WaitW-1:0]  WaitMax   = WaitW'(MEM_TIMEOUT);
  localparam logic [DrainW-1:0] DrainDone = DrainW'(DRAIN_CYCLES);

  ctrl_state_t       state_q, state_d;
  logic [WaitW-1:0]  wait_q, wait_d;
  logic [DrainW-1:0] drain_q, drain_d;
  logic              halted_q, halted_d;
  logic              mem_err_q, mem_err_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic [CNT_W-1:0]  flush_q, flush_d;

  pipe_ctrl_t ctrl;
  logic       lu_hazard;
  logic       mem_stall;
  logic       redirect_taken;

  load_use_detect u_load_use_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .lu_hazard   (lu_hazard)
  );

  always_comb begin
    state_d        = state_q;
    drain_d        = drain_q;
    ctrl           = CtrlNormal;
    mem_stall      = 1'b0;
    redirect_taken = 1'b0;

    unique case (state_q)
      StRun, StMemWait: begin
        // Once waiting, only mem_ready releases the freeze.
        mem_stall = (state_q == StMemWait) ? !mem_ready : (mem_req && !mem_ready);
        if (mem_stall) begin
          ctrl    = CtrlFreeze;
          state_d = StMemWait;
        end else begin
          state_d = StRun;
          if (ex_redirect) begin
            // The instruction in ID is squashed, so its halt/load-use are irrelevant.
            ctrl.if_id_flush = 1'b1;
            ctrl.id_ex_flush = 1'b1;
            redirect_taken   = 1'b1;
          end else if (id_halt) begin
            // Halt itself moves on to EX; nothing new is fetched behind it.
            ctrl.pc_en       = 1'b0;
            ctrl.if_id_flush = 1'b1;
            state_d          = StDrain;
            drain_d          = '0;
          end else if (lu_hazard) begin
            ctrl.pc_en       = 1'b0;
            ctrl.if_id_en    = 1'b0;
            ctrl.id_ex_flush = 1'b1;
          end
        end
      end
      StDrain: begin
        mem_stall = mem_req && !mem_ready;
        if (mem_stall) begin
          ctrl = CtrlFreeze;
        end else begin
          ctrl    = CtrlDrain;
          drain_d = drain_q + 1'b1;
          if (drain_d == DrainDone) begin
            state_d = StHalted;
          end
        end
      end
      StHalted: begin
        ctrl = CtrlFreeze;
      end
      default: begin
        state_d = StRun;
      end
    endcase

    // Wait counter saturates at the timeout so it cannot wrap during a long stall.
    if (mem_stall) begin
      wait_d = (wait_q == WaitMax) ? wait_q : wait_q + 1'b1;
    end else begin
      wait_d = '0;
    end

    mem_err_d = mem_err_q | (mem_stall && (wait_d == WaitMax));
    halted_d  = (state_d == StHalted);

    stall_d = stall_q;
    if (!ctrl.pc_en && (state_q != StHalted) && (stall_q != '1)) begin
      stall_d = stall_q + 1'b1;
    end

    flush_d = flush_q;
    if (redirect_taken && (flush_q != '1)) begin
      flush_d = flush_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StRun;
      wait_q    <= '0;
      drain_q   <= '0;
      halted_q  <= 1'b0;
      mem_err_q <= 1'b0;
      stall_q   <= '0;
      flush_q   <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      drain_q   <= drain_d;
      halted_q  <= halted_d;
      mem_err_q <= mem_err_d;
      stall_q   <= stall_d;
      flush_q   <= flush_d;
    end
  end

  assign pc_en       = ctrl.pc_en;
  assign if_id_en    = ctrl.if_id_en;
  assign if_id_flush = ctrl.if_id_flush;
  assign id_ex_en    = ctrl.id_ex_en;
  assign id_ex_flush = ctrl.id_ex_flush;
  assign ex_mem_en   = ctrl.ex_mem_en;
  assign mem_wb_en   = ctrl.mem_wb_en;
  assign halted      = halted_q;
  assign mem_err     = mem_err_q;
  assign stall_cnt   = stall_q;
  assign flush_cnt   = flush_q;

endmodule
